// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the accumulator CPU bus.
// A DEPTH-word array behind a request/response valid-ready handshake.
// Each request waits WAIT_CYCLES extra cycles before its response.
// Addresses at or above DEPTH return an error response.
module mem_responder #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [DATA_W-1:0] mem_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Counter start value; the WAIT state lasts WAIT_CYCLES cycles.
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t              state;
  logic [3:0]          cnt;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                commit;
  logic                c_write;
  logic [ADDR_W-1:0]   c_addr;
  logic [DATA_W-1:0]   c_wdata;
  logic                c_mapped;
  logic [DATA_W-1:0]   rd_word;

  assign accept = (state == IDLE) && req_valid && req_ready;

  // Select the access committed on the edge that enters RESP.
  // With no wait states the live request commits on its accept edge.
  always_comb begin
    commit  = 1'b0;
    c_write = wr_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    if (WAIT_CYCLES == 0) begin
      commit  = accept && reset_n;
      c_write = req_write;
      c_addr  = req_addr;
      c_wdata = req_wdata;
    end else begin
      commit  = (state == WAIT) && (cnt == 4'd0) && reset_n;
    end
  end

  assign c_mapped = 32'(c_addr) < 32'(DEPTH);
  assign rd_word  = mem[c_addr];

  // Capture the request on accept; payload needs no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Array store at commit; contents survive reset.
  always_ff @(posedge clock) begin
    if (commit && c_mapped && c_write) begin
      mem[c_addr] <= c_wdata;
    end
  end

  // Control FSM with registered handshake, response and status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_out   <= '0;
      busy      <= 1'b0;
    end else begin
      if (commit) begin
        rsp_rdata <= (c_mapped && !c_write) ? rd_word : '0;
        rsp_err   <= !c_mapped;
        if (c_mapped && c_write) begin
          mem_out <= c_wdata;
        end
      end
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder.
// u0: DEPTH=100, WAIT_CYCLES=1. u1: DEPTH=128, WAIT_CYCLES=0.
module tb_mem_responder;

  logic        clock;
  logic        reset_n;

  logic        req_valid, req_ready, req_write;
  logic [6:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [15:0] rsp_rdata, mem_out;

  logic        s_req_valid, s_req_ready, s_req_write;
  logic [6:0]  s_req_addr;
  logic [15:0] s_req_wdata;
  logic        s_rsp_valid, s_rsp_ready, s_rsp_err, s_busy;
  logic [15:0] s_rsp_rdata, s_mem_out;

  int total = 0;
  int bad   = 0;

  logic [16:0] q0[$];
  logic [16:0] q1[$];
  logic [15:0] model0 [0:127];
  logic [15:0] model1 [0:127];
  logic [15:0] m0_out;
  logic [15:0] m1_out;

  mem_responder #(.ADDR_W(7), .DATA_W(16), .DEPTH(100), .WAIT_CYCLES(1)) u0 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_out(mem_out), .busy(busy)
  );

  mem_responder #(.ADDR_W(7), .DATA_W(16), .DEPTH(128), .WAIT_CYCLES(0)) u1 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_write(s_req_write),
    .req_addr(s_req_addr), .req_wdata(s_req_wdata),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_rdata(s_rsp_rdata),
    .rsp_err(s_rsp_err), .mem_out(s_mem_out), .busy(s_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model for u0 (100 mapped words): returns {rdata, err}.
  function automatic logic [16:0] m0_step(input logic w, input logic [6:0] a, input logic [15:0] d);
    if (a >= 7'd100) return {16'h0000, 1'b1};
    if (w) begin
      model0[a] = d;
      m0_out    = d;
      return 17'h0;
    end
    return {model0[a], 1'b0};
  endfunction

  // Reference model for u1 (all 128 words mapped).
  function automatic logic [16:0] m1_step(input logic w, input logic [6:0] a, input logic [15:0] d);
    if (w) begin
      model1[a] = d;
      m1_out    = d;
      return 17'h0;
    end
    return {model1[a], 1'b0};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Full transaction on u0; reports response, latency from the accept
  // cycle, and whether req_ready stayed low while the request was in flight.
  task automatic xfer(input logic w, input logic [6:0] a, input logic [15:0] d,
                      output logic [15:0] rd, output logic er, output int lat, output logic held);
    int n;
    held      = 1'b1;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      if (req_ready) held = 1'b0;
      tick();
      lat++;
    end
    if (req_ready) held = 1'b0;
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    total++; if ({rsp_rdata, rsp_err} !== 17'h0) begin bad++; $display("FAIL rst_rsp: got %h/%b want 0/0", rsp_rdata, rsp_err); end
    total++; if ({mem_out, busy} !== 17'h0) begin bad++; $display("FAIL rst_memout_busy: got %h/%b want 0/0", mem_out, busy); end
    total++; if ({s_req_ready, s_rsp_valid, s_busy, s_mem_out} !== 19'h40000) begin bad++; $display("FAIL rst_u1: got %b%b%b/%h want 100/0", s_req_ready, s_rsp_valid, s_busy, s_mem_out); end
    @(negedge clock);
    reset_n = 1'b1;
    // A stray rsp_ready while idle must be ignored.
    rsp_ready = 1'b1;
    tick();
    tick();
    total++; if ({rsp_valid, busy, req_ready} !== 3'b001) begin bad++; $display("FAIL idle_rsp_ready: got %b%b%b want 001", rsp_valid, busy, req_ready); end
    rsp_ready = 1'b0;
    tick();
  endtask

  // Streams four requests to u1 at addresses 10..13 with rsp_ready held high.
  task automatic test_stream(input logic w);
    logic [15:0] dat [4];
    logic [16:0] e;
    int idx, got, last, cyc;
    dat[0] = 16'h001A; dat[1] = 16'h801B; dat[2] = 16'h0419; dat[3] = 16'h6500;
    idx = 0; got = 0; last = -1; cyc = 0;
    s_rsp_ready = 1'b1;
    while (got < 4 && cyc < 40) begin
      if (s_req_ready) begin
        if (idx < 4) begin
          s_req_valid = 1'b1;
          s_req_write = w;
          s_req_addr  = 7'(10 + idx);
          s_req_wdata = dat[idx];
          q1.push_back(m1_step(w, 7'(10 + idx), dat[idx]));
          idx++;
        end else begin
          s_req_valid = 1'b0;
        end
      end
      tick();
      cyc++;
      if (s_rsp_valid) begin
        e = q1.pop_front();
        total++; if ({s_rsp_rdata, s_rsp_err} !== e) begin bad++; $display("FAIL stream_w%0b_%0d: got %h/%b want %h/%b", w, got, s_rsp_rdata, s_rsp_err, e[16:1], e[0]); end
        if (last >= 0) begin
          total++; if (cyc - last != 2) begin bad++; $display("FAIL stream_gap_w%0b_%0d: got %0d want 2", w, got, cyc - last); end
        end
        last = cyc;
        got++;
      end
    end
    s_req_valid = 1'b0;
    tick();
    s_rsp_ready = 1'b0;
    total++; if (got != 4) begin bad++; $display("FAIL stream_count_w%0b: got %0d want 4", w, got); end
    total++; if (s_mem_out !== m1_out) begin bad++; $display("FAIL stream_memout_w%0b: got %h want %h", w, s_mem_out, m1_out); end
  endtask

  task automatic test_read_latency();
    logic [15:0] rd; logic er, held; logic [16:0] e; int lat;
    q0.push_back(m0_step(1'b1, 7'd25, 16'd18));
    xfer(1'b1, 7'd25, 16'd18, rd, er, lat, held);
    e = q0.pop_front();
    total++; if ({rd, er} !== e) begin bad++; $display("FAIL wr25: got %h/%b want %h/%b", rd, er, e[16:1], e[0]); end
    q0.push_back(m0_step(1'b0, 7'd25, 16'h0));
    xfer(1'b0, 7'd25, 16'h0, rd, er, lat, held);
    e = q0.pop_front();
    total++; if ({rd, er} !== e) begin bad++; $display("FAIL rd25: got %h/%b want %h/%b", rd, er, e[16:1], e[0]); end
    total++; if (lat != 2) begin bad++; $display("FAIL rd25_latency: got %0d want 2", lat); end
    total++; if (held !== 1'b1) begin bad++; $display("FAIL rd25_ready_low: got %b want 1", held); end
  endtask

  task automatic test_raw();
    logic [15:0] rd; logic er, held; logic [16:0] e; int lat;
    q0.push_back(m0_step(1'b1, 7'd30, 16'h0005));
    xfer(1'b1, 7'd30, 16'h0005, rd, er, lat, held);
    e = q0.pop_front();
    total++; if ({rd, er} !== e) begin bad++; $display("FAIL wr30: got %h/%b want %h/%b", rd, er, e[16:1], e[0]); end
    total++; if (mem_out !== m0_out) begin bad++; $display("FAIL wr30_memout: got %h want %h", mem_out, m0_out); end
    q0.push_back(m0_step(1'b0, 7'd30, 16'h0));
    xfer(1'b0, 7'd30, 16'h0, rd, er, lat, held);
    e = q0.pop_front();
    total++; if ({rd, er} !== e) begin bad++; $display("FAIL rd30: got %h/%b want %h/%b", rd, er, e[16:1], e[0]); end
  endtask

  task automatic test_unmapped();
    logic [15:0] rd; logic er, held; logic [16:0] e; int lat;
    q0.push_back(m0_step(1'b1, 7'd10, 16'h001A));
    xfer(1'b1, 7'd10, 16'h001A, rd, er, lat, held);
    e = q0.pop_front();
    total++; if ({rd, er} !== e) begin bad++; $display("FAIL wr10: got %h/%b want %h/%b", rd, er, e[16:1], e[0]); end
    q0.push_back(m0_step(1'b0, 7'd30, 16'h0));
    xfer(1'b0, 7'd30, 16'h0, rd, er, lat, held);
    e = q0.pop_front();
    q0.push_back(m0_step(1'b0, 7'd120, 16'h0));
    xfer(1'b0, 7'd120, 16'h0, rd, er, lat, held);
    e = q0.pop_front();
    total++; if ({rd, er} !== e) begin bad++; $display("FAIL rd120: got %h/%b want %h/%b", rd, er, e[16:1], e[0]); end
    q0.push_back(m0_step(1'b1, 7'd110, 16'hBEEF));
    xfer(1'b1, 7'd110, 16'hBEEF, rd, er, lat, held);
    e = q0.pop_front();
    total++; if ({rd, er} !== e) begin bad++; $display("FAIL wr110: got %h/%b want %h/%b", rd, er, e[16:1], e[0]); end
    total++; if (mem_out !== m0_out) begin bad++; $display("FAIL wr110_memout: got %h want %h", mem_out, m0_out); end
    q0.push_back(m0_step(1'b0, 7'd10, 16'h0));
    xfer(1'b0, 7'd10, 16'h0, rd, er, lat, held);
    e = q0.pop_front();
    total++; if ({rd, er} !== e) begin bad++; $display("FAIL rd10_after_110: got %h/%b want %h/%b", rd, er, e[16:1], e[0]); end
  endtask

  task automatic test_backpressure();
    logic [16:0] e; int n;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 7'd10; req_wdata = 16'h0;
    q0.push_back(m0_step(1'b0, 7'd10, 16'h0));
    tick();
    // A competing request stays asserted while the response is pending.
    req_addr = 7'd25;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    e = q0.pop_front();
    total++; if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b1, e}) begin bad++; $display("FAIL bp_first: got %b %h/%b want 1 %h/%b", rsp_valid, rsp_rdata, rsp_err, e[16:1], e[0]); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if ({rsp_valid, rsp_rdata, rsp_err, req_ready} !== {1'b1, e, 1'b0}) begin bad++; $display("FAIL bp_hold_%0d: got v%b %h/%b rdy%b want v1 %h/%b rdy0", i, rsp_valid, rsp_rdata, rsp_err, req_ready, e[16:1], e[0]); end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++; if ({rsp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL bp_release: got v%b rdy%b want v0 rdy1", rsp_valid, req_ready); end
    q0.push_back(m0_step(1'b0, 7'd25, 16'h0));
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    e = q0.pop_front();
    total++; if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b1, e}) begin bad++; $display("FAIL bp_second: got %b %h/%b want 1 %h/%b", rsp_valid, rsp_rdata, rsp_err, e[16:1], e[0]); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_wait();
    logic [15:0] rd; logic er, held; logic [16:0] e; int lat;
    q0.push_back(m0_step(1'b1, 7'd40, 16'h0777));
    xfer(1'b1, 7'd40, 16'h0777, rd, er, lat, held);
    e = q0.pop_front();
    // Leave a nonzero load result on rsp_rdata before the reset.
    q0.push_back(m0_step(1'b0, 7'd25, 16'h0));
    xfer(1'b0, 7'd25, 16'h0, rd, er, lat, held);
    e = q0.pop_front();
    total++; if ({rd, er} !== e) begin bad++; $display("FAIL rw_pre25: got %h/%b want %h/%b", rd, er, e[16:1], e[0]); end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 7'd40; req_wdata = 16'h1234;
    tick();
    req_valid = 1'b0;
    total++; if ({busy, rsp_valid} !== 2'b10) begin bad++; $display("FAIL rw_in_wait: got busy%b v%b want busy1 v0", busy, rsp_valid); end
    reset_n = 1'b0;
    #1;
    m0_out = 16'h0;
    total++; if ({req_ready, rsp_valid, busy, rsp_err} !== 4'b1000) begin bad++; $display("FAIL rw_ctrl: got %b%b%b%b want 1000", req_ready, rsp_valid, busy, rsp_err); end
    total++; if ({rsp_rdata, mem_out} !== 32'h0) begin bad++; $display("FAIL rw_data: got %h/%h want 0/0", rsp_rdata, mem_out); end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    q0.push_back(m0_step(1'b0, 7'd40, 16'h0));
    xfer(1'b0, 7'd40, 16'h0, rd, er, lat, held);
    e = q0.pop_front();
    total++; if ({rd, er} !== e) begin bad++; $display("FAIL rw_rd40: got %h/%b want %h/%b", rd, er, e[16:1], e[0]); end
    total++; if (mem_out !== m0_out) begin bad++; $display("FAIL rw_memout: got %h want %h", mem_out, m0_out); end
  endtask

  task automatic test_reset_resp();
    logic [15:0] rd; logic er, held; logic [16:0] e; int lat, n;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 7'd41; req_wdata = 16'h4141;
    e = m0_step(1'b1, 7'd41, 16'h4141);
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    total++; if ({rsp_valid, mem_out} !== {1'b1, 16'h4141}) begin bad++; $display("FAIL rr_resp: got v%b %h want v1 4141", rsp_valid, mem_out); end
    reset_n = 1'b0;
    #1;
    m0_out = 16'h0;
    total++; if ({rsp_valid, mem_out} !== 17'h0) begin bad++; $display("FAIL rr_drop: got v%b %h want v0 0000", rsp_valid, mem_out); end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    q0.push_back(m0_step(1'b0, 7'd41, 16'h0));
    xfer(1'b0, 7'd41, 16'h0, rd, er, lat, held);
    e = q0.pop_front();
    total++; if ({rd, er} !== e) begin bad++; $display("FAIL rr_rd41: got %h/%b want %h/%b", rd, er, e[16:1], e[0]); end
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 7'd0; req_wdata = 16'h0; rsp_ready = 1'b0;
    s_req_valid = 1'b0; s_req_write = 1'b0; s_req_addr = 7'd0; s_req_wdata = 16'h0; s_rsp_ready = 1'b0;
    m0_out = 16'h0;
    m1_out = 16'h0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_stream(1'b1);
    test_stream(1'b0);
    test_read_latency();
    test_raw();
    test_unmapped();
    test_backpressure();
    test_reset_wait();
    test_reset_resp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the 16-bit accumulator-style CPU's memory bus: 128 x 16-bit word array served through a request/response valid-ready handshake.
- The CPU fetch/operand/store cycles act as initiator; this block is the other end, adding configurable wait states and an error response for unmapped addresses.
- Sits between the CPU core and the program/data store. Replaces direct array indexing by the core.

Parameters:
ADDR_W, 7, word-address width (matches 7-bit PC/MAR)
DATA_W, 16, word width
DEPTH, 128, implemented words; addresses >= DEPTH are unmapped
WAIT_CYCLES, 1, extra cycles between request accept and response (0..15)

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  initiator presents a request
req_ready  output  1  responder can accept a request
req_write  input  1  1 = store, 0 = load
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  store data
rsp_valid  output  1  response available
rsp_ready  input  1  initiator accepts response
rsp_rdata  output  DATA_W  load data (0 for writes and errors)
rsp_err  output  1  address was unmapped
mem_out  output  DATA_W  last successfully stored word
busy  output  1  request in flight (state != IDLE)

Behaviour:
- Reset (async assert, sync deassert handled by the integrator): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_out=0, busy=0, wait counter=0. Array contents are NOT reset.
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch write/addr/wdata. Go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else go to RESP.
- WAIT: req_ready=0. Counter decrements each cycle; leave for RESP on the cycle the counter is 0.
- Access commit, on the edge that enters RESP:
  - Read: rsp_rdata=array[addr].
  - Write: array[addr]=wdata, mem_out=wdata, rsp_rdata=0.
  - Unmapped address (addr>=DEPTH): no array or mem_out change, rsp_rdata=0, rsp_err=1. Otherwise rsp_err=0.
- RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until the handshake completes. On rsp_ready go to IDLE; rsp_valid falls next cycle.
- Latency: rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge. Minimum back-to-back throughput is one request per WAIT_CYCLES+2 cycles with rsp_ready held high.
- Only one outstanding request; no request is accepted while a response is pending.
- req_valid may drop or change while req_ready=0; no effect.
- rsp_ready asserted while rsp_valid=0 is ignored.
- Read-after-write: a read issued after a write's response to the same address returns the new data.
- Reset mid-operation in WAIT discards the request: no write occurs. Reset in RESP drops the response; an already-committed write persists.
- Arithmetic: wait counter is 4-bit and never wraps below 0. Addresses are unsigned.

Test Plan:
- Preload array[25]=18. WAIT_CYCLES=1. Read addr 25 -> rsp_valid 2 cycles after accept, rsp_rdata=18, rsp_err=0, req_ready=0 until handshake.
- Write addr 30 data 0x0005, then read addr 30 -> write response rsp_rdata=0, mem_out=0x0005; read returns 0x0005.
- DEPTH=100, read addr 120 and write addr 110 data 0xBEEF -> both rsp_err=1, rsp_rdata=0; array[110 mod] untouched, mem_out unchanged.
- Hold rsp_ready=0 for 5 cycles after a read of addr 10 (=0x001A) -> rsp_valid and rsp_rdata=0x001A stable all 5 cycles; a new req_valid is not accepted; accepted only after rsp_ready pulse.
- WAIT_CYCLES=0, rsp_ready=1, stream reads of addr 10..13 -> one response every 2 cycles, data 0x001A, 0x801B, 0x0419, 0x6500 in order.
- Write addr 40 data 0x1234 accepted, assert reset_n=0 during WAIT -> outputs return to reset values immediately; subsequent read of addr 40 returns its prior value, mem_out=0.
